window_stream_memory: RTL and testbench
=======================================

Name: window_stream_memory

Overview:
- Multi-lane image memory with an autonomous sliding-window read engine; feeds K×K convolution windows to the MAC array.
- Each of NUM_UNITS lanes holds one image plane; all lanes are read in lockstep.
- Successor to the step-driven dual memory. Adds runtime stride, a hardware window-scan FSM, valid/ready backpressure, window framing markers, abort, and config-error detection.

Parameters:
DATA_WIDTH, 16, lane word width
IMAGE_WIDTH, 4, pixels per row
IMAGE_HEIGHT, 4, rows
NUM_UNITS, 2, lanes (image planes)
MAX_KERNEL, 3, largest supported kernel_dim
(derived) MEM_DEPTH = IMAGE_WIDTH*IMAGE_HEIGHT; AW = $clog2(MEM_DEPTH); KW = $clog2(MAX_KERNEL+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
wr_en  in  NUM_UNITS  per-lane write enable
wr_addr  in  AW  write address, shared by all lanes
wr_data  in  NUM_UNITS×DATA_WIDTH  write data per lane
start  in  1  pulse; launches a scan when IDLE
kernel_dim  in  KW  K, sampled on start
stride  in  KW  S, sampled on start
abort  in  1  synchronous abort of the scan
out_valid  out  1  out_data holds a valid beat
out_ready  in  1  consumer accepts the beat
out_data  out  NUM_UNITS×DATA_WIDTH  one kernel element per lane
out_first  out  1  beat is element (0,0) of a window
out_last  out  1  beat is element (K-1,K-1) of a window
busy  out  1  FSM not IDLE
done  out  1  one-cycle pulse after the final beat is accepted
cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset: FSM goes to IDLE. Buffer and in-flight flag are cleared. All outputs are 0. Memory contents are undefined.
- Memory:
  - One write port and one read port per lane. Synchronous read, 1-cycle latency.
  - Same-address write and read in one cycle: read returns old data (read-first).
  - Writes are accepted in any state.
- Config check on start while IDLE:
  - Reject if K==0, K>MAX_KERNEL, K>IMAGE_WIDTH, K>IMAGE_HEIGHT, or S==0.
  - On reject: cfg_err=1 next cycle, stay IDLE.
  - start while busy is ignored.
- Window counts:
  - NWX = (IMAGE_WIDTH-K)/S+1 and NWY = (IMAGE_HEIGHT-K)/S+1, floor division.
  - Origins not fitting a full window are skipped.
- Scan order:
  - Window origin (wy,wx) in raster order, stepping by S.
  - Within a window, ky outer, kx inner.
  - Read address = (wy+ky)*IMAGE_WIDTH + wx+kx.
- FSM states:
  - IDLE: on valid start, go to RUN.
  - RUN: issue reads. After the last address is issued, go to DRAIN.
  - DRAIN: wait until the buffer is empty and no read is in flight. Then pulse done and go to IDLE.
- Flow control:
  - 2-entry output FIFO; out_* is driven from its head.
  - A read is issued only when (FIFO count + in-flight) < 2, or == 2 with a pop in the same cycle.
  - Result: full throughput (1 beat/cycle) when out_ready is held 1, and no beat is lost or duplicated under backpressure.
- Latency: first out_valid appears 2 cycles after the start edge.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_first and out_last hold stable.
- Beats per scan: NWX*NWY*K*K.
- Abort: in any state, next cycle go to IDLE. Flush the FIFO and discard the in-flight read. out_valid=0, no done.
- start and abort in the same cycle: abort wins.
- Asynchronous reset mid-scan behaves the same as abort, plus outputs clear immediately.

Decomposition:
- Package ttpu_mem_pkg holds:
  - the scan state enum (IDLE, RUN, DRAIN);
  - the lane-data typedef (logic [DATA_WIDTH-1:0]);
  - the address-width helper function.
- Sub-module window_addr_gen holds the wx/wy/kx/ky counters and the address and first/last computation. It is stepped by an advance input and flags last_addr.
- The memory array, FIFO and FSM live in the top.

Test Plan:
- Write lane0[a]=a+1 and lane1[a]=a+100 for a=0..15. Run K=2, S=2, out_ready=1 → 16 beats, 4 windows. Window 0 lane0 = 1,2,5,6 with first on 1 and last on 6. Window 3 lane0 = 11,12,15,16. done pulses once.
- Same data, K=3, S=1 → 36 beats. Last window lane0 = 6,7,8,10,11,12,14,15,16. Lane1 on the last beat = 115.
- K=2, S=2 with out_ready toggling 1,0,0,1 → identical 16-beat sequence. Data is stable during stalls. Beats per cycle ≤ 1.
- Reject cases: start with K=0, K=4, or S=0 → cfg_err pulse, busy stays 0, no out_valid.
- K=3, S=3 → NWX=NWY=1, 9 beats, origin 0 only.
- Mid-scan events:
  - abort after 5 accepted beats → out_valid=0 next cycle, busy=0, no done; a new start then replays from beat 0.
  - reset asserted mid-scan → all outputs 0 immediately.

Source files
------------

// File: rtl/ttpu_mem_pkg.sv
// Shared types and helpers for the window stream memory.
package ttpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } scan_state_t;

    localparam int unsigned LANE_WIDTH = 16;

    typedef logic [LANE_WIDTH-1:0] lane_t;

    // Index width for a table of `depth` entries, never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Sliding-window address sequencer: walks window origins in raster order by
// stride, and kernel elements ky-outer / kx-inner inside each window.
module window_addr_gen
    import ttpu_mem_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = 4,
    parameter int unsigned IMAGE_HEIGHT = 4,
    parameter int unsigned MAX_KERNEL   = 3,
    localparam int unsigned AW = addr_width(IMAGE_WIDTH * IMAGE_HEIGHT),
    localparam int unsigned KW = $clog2(MAX_KERNEL + 1),
    localparam int unsigned XW = addr_width(IMAGE_WIDTH),
    localparam int unsigned YW = addr_width(IMAGE_HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          advance,
    input  logic [KW-1:0] kernel_dim,
    input  logic [KW-1:0] stride,
    output logic [AW-1:0] addr_c,
    output logic          first_c,
    output logic          last_c,
    output logic          last_addr_c
);

    localparam int IW = int'(IMAGE_WIDTH);
    localparam int IH = int'(IMAGE_HEIGHT);

    logic [KW-1:0] k_q;
    logic [KW-1:0] s_q;
    logic [KW-1:0] kx_q;
    logic [KW-1:0] ky_q;
    logic [XW-1:0] wx_q;
    logic [YW-1:0] wy_q;

    logic kx_end;
    logic ky_end;
    logic wx_end;
    logic wy_end;
    int   k_i;
    int   s_i;
    int   kx_i;
    int   ky_i;
    int   wx_i;
    int   wy_i;

    // An origin is the last in its row/column when one more stride would
    // no longer leave room for a full window.
    always_comb begin
        k_i         = 32'(k_q);
        s_i         = 32'(s_q);
        kx_i        = 32'(kx_q);
        ky_i        = 32'(ky_q);
        wx_i        = 32'(wx_q);
        wy_i        = 32'(wy_q);
        kx_end      = (kx_i == k_i - 1);
        ky_end      = (ky_i == k_i - 1);
        wx_end      = (wx_i + s_i > IW - k_i);
        wy_end      = (wy_i + s_i > IH - k_i);
        addr_c      = AW'((wy_i + ky_i) * IW + wx_i + kx_i);
        first_c     = (kx_i == 0) && (ky_i == 0);
        last_c      = kx_end && ky_end;
        last_addr_c = last_c && wx_end && wy_end;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q  <= '0;
            s_q  <= '0;
            kx_q <= '0;
            ky_q <= '0;
            wx_q <= '0;
            wy_q <= '0;
        end else if (load) begin
            k_q  <= kernel_dim;
            s_q  <= stride;
            kx_q <= '0;
            ky_q <= '0;
            wx_q <= '0;
            wy_q <= '0;
        end else if (advance) begin
            if (!kx_end) begin
                kx_q <= kx_q + KW'(1);
            end else begin
                kx_q <= '0;
                if (!ky_end) begin
                    ky_q <= ky_q + KW'(1);
                end else begin
                    ky_q <= '0;
                    if (!wx_end) begin
                        wx_q <= XW'(wx_i + s_i);
                    end else begin
                        wx_q <= '0;
                        wy_q <= wy_end ? '0 : YW'(wy_i + s_i);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/window_stream_memory.sv
// Multi-lane image memory with an autonomous K x K sliding-window read engine
// feeding a 2-entry valid/ready output FIFO.
module window_stream_memory
    import ttpu_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = $bits(lane_t),
    parameter int unsigned IMAGE_WIDTH  = 4,
    parameter int unsigned IMAGE_HEIGHT = 4,
    parameter int unsigned NUM_UNITS    = 2,
    parameter int unsigned MAX_KERNEL   = 3,
    localparam int unsigned MEM_DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT,
    localparam int unsigned AW        = addr_width(MEM_DEPTH),
    localparam int unsigned KW        = $clog2(MAX_KERNEL + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_UNITS-1:0]            wr_en,
    input  logic [AW-1:0]                   wr_addr,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] wr_data,
    input  logic                            start,
    input  logic [KW-1:0]                   kernel_dim,
    input  logic [KW-1:0]                   stride,
    input  logic                            abort,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_UNITS*DATA_WIDTH-1:0] out_data,
    output logic                            out_first,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done,
    output logic                            cfg_err
);

    localparam int unsigned LW = NUM_UNITS * DATA_WIDTH;

    scan_state_t state;
    scan_state_t state_nx;

    logic [LW-1:0] rd_word;
    logic          inflight;
    logic          inflight_first;
    logic          inflight_last;
    logic [1:0]    count;
    logic [1:0]    count_nx;
    logic [1:0]    fill_c;
    logic [LW-1:0] e1_data;
    logic          e1_first;
    logic          e1_last;

    logic [AW-1:0] rd_addr_c;
    logic          addr_first_c;
    logic          addr_last_c;
    logic          last_addr_c;
    logic          cfg_ok_c;
    logic          load_c;
    logic          issue_c;
    logic          pop_c;
    logic          push_c;
    logic          done_nx;
    logic          cfg_err_nx;

    assign cfg_ok_c = (kernel_dim != '0) && (stride != '0)
                   && (32'(kernel_dim) <= MAX_KERNEL)
                   && (32'(kernel_dim) <= IMAGE_WIDTH)
                   && (32'(kernel_dim) <= IMAGE_HEIGHT);

    window_addr_gen #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT),
        .MAX_KERNEL   (MAX_KERNEL)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .load        (load_c),
        .advance     (issue_c),
        .kernel_dim  (kernel_dim),
        .stride      (stride),
        .addr_c      (rd_addr_c),
        .first_c     (addr_first_c),
        .last_c      (addr_last_c),
        .last_addr_c (last_addr_c)
    );

    // Read-first synchronous lane memories.
    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
        logic [DATA_WIDTH-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (wr_en[u]) begin
                mem[wr_addr] <= wr_data[u*DATA_WIDTH +: DATA_WIDTH];
            end
            if (issue_c) begin
                rd_q <= mem[rd_addr_c];
            end
        end

        assign rd_word[u*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end

    // Next state; a read issues only if its result is guaranteed a FIFO slot.
    always_comb begin
        state_nx   = state;
        load_c     = 1'b0;
        issue_c    = 1'b0;
        done_nx    = 1'b0;
        cfg_err_nx = 1'b0;
        pop_c      = out_valid && out_ready && !abort;
        push_c     = inflight && !abort;
        fill_c     = count + 2'(inflight);
        count_nx   = count - 2'(pop_c) + 2'(push_c);
        if (abort) begin
            state_nx = ST_IDLE;
            count_nx = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_ok_c) begin
                            state_nx = ST_RUN;
                            load_c   = 1'b1;
                        end else begin
                            cfg_err_nx = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if ((fill_c < 2'd2) || ((fill_c == 2'd2) && pop_c)) begin
                        issue_c = 1'b1;
                        if (last_addr_c) begin
                            state_nx = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (count_nx == 2'd0) begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nx;
            busy    <= (state_nx != ST_IDLE);
            done    <= done_nx;
            cfg_err <= cfg_err_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight       <= 1'b0;
            inflight_first <= 1'b0;
            inflight_last  <= 1'b0;
        end else begin
            inflight <= issue_c;
            if (issue_c) begin
                inflight_first <= addr_first_c;
                inflight_last  <= addr_last_c;
            end
        end
    end

    // Shift FIFO: entry 0 is the registered output head, entry 1 backs it up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            e1_data   <= '0;
            e1_first  <= 1'b0;
            e1_last   <= 1'b0;
        end else begin
            count     <= count_nx;
            out_valid <= (count_nx != 2'd0);
            if (pop_c) begin
                out_data  <= e1_data;
                out_first <= e1_first;
                out_last  <= e1_last;
            end
            if (push_c) begin
                if ((count - 2'(pop_c)) == 2'd0) begin
                    out_data  <= rd_word;
                    out_first <= inflight_first;
                    out_last  <= inflight_last;
                end else begin
                    e1_data  <= rd_word;
                    e1_first <= inflight_first;
                    e1_last  <= inflight_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_window_stream_memory.sv
// Directed self-checking bench for window_stream_memory.
module tb_window_stream_memory;

    localparam int unsigned DW = 16;
    localparam int unsigned NU = 2;
    localparam int unsigned AW = 4;
    localparam int unsigned KW = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NU-1:0]    wr_en = '0;
    logic [AW-1:0]    wr_addr = '0;
    logic [NU*DW-1:0] wr_data = '0;
    logic             start = 1'b0;
    logic [KW-1:0]    kernel_dim = '0;
    logic [KW-1:0]    stride = '0;
    logic             abort = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [NU*DW-1:0] out_data;
    logic             out_first;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             cfg_err;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] b_l0[$];
    logic [DW-1:0] b_l1[$];
    logic          b_first[$];
    logic          b_last[$];
    int            done_cnt;

    int exp_k2s2[16] = '{1, 2, 5, 6, 3, 4, 7, 8, 9, 10, 13, 14, 11, 12, 15, 16};
    int exp_k3s3[9]  = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    int exp_k3s1_tail[9] = '{6, 7, 8, 10, 11, 12, 14, 15, 16};

    window_stream_memory dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .kernel_dim (kernel_dim),
        .stride     (stride),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_first  (out_first),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic load_memory();
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            wr_en   = 2'b11;
            wr_addr = AW'(a);
            wr_data = {16'(a + 100), 16'(a + 1)};
        end
        @(negedge clk);
        wr_en = '0;
    endtask

    // Launches a scan and logs every accepted beat; all activity on negedges.
    task automatic run_scan(input int k, input int s, input bit stall,
                            output int lat, output int stall_bad, output bit tmo);
        bit            pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit            holding;
        logic [NU*DW-1:0] hd;
        logic          hf;
        logic          hl;
        int            ph;
        b_l0.delete();
        b_l1.delete();
        b_first.delete();
        b_last.delete();
        done_cnt  = 0;
        lat       = -1;
        stall_bad = 0;
        tmo       = 1'b1;
        holding   = 1'b0;
        hd        = '0;
        hf        = 1'b0;
        hl        = 1'b0;
        ph        = 0;
        @(negedge clk);
        start      = 1'b1;
        kernel_dim = KW'(k);
        stride     = KW'(s);
        out_ready  = 1'b1;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) done_cnt++;
            if (out_valid && lat < 0) lat = c - 1;
            if (holding && (!out_valid || out_data !== hd || out_first !== hf || out_last !== hl))
                stall_bad++;
            out_ready = stall ? pat[ph] : 1'b1;
            ph = (ph + 1) % 4;
            if (out_valid && out_ready) begin
                b_l0.push_back(out_data[DW-1:0]);
                b_l1.push_back(out_data[2*DW-1:DW]);
                b_first.push_back(out_first);
                b_last.push_back(out_last);
                holding = 1'b0;
            end else begin
                holding = out_valid;
                hd      = out_data;
                hf      = out_first;
                hl      = out_last;
            end
            if (!busy) begin
                tmo = 1'b0;
                break;
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, busy, done, cfg_err, out_first, out_last} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000000",
                     {out_valid, busy, done, cfg_err, out_first, out_last});
        end
        checks++;
        if (out_data !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", out_data);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, busy, done, cfg_err} !== 4'b0) begin
            failures++;
            $display("FAIL post_reset_idle got=%b want=0000", {out_valid, busy, done, cfg_err});
        end
    endtask

    task automatic test_k2s2(input bit stall, input string tag);
        int lat;
        int sbad;
        bit tmo;
        run_scan(2, 2, stall, lat, sbad, tmo);
        checks++;
        if (tmo) begin
            failures++;
            $display("FAIL %s_timeout got=busy_stuck want=idle", tag);
        end
        checks++;
        if (lat != 2) begin
            failures++;
            $display("FAIL %s_latency got=%0d want=2", tag, lat);
        end
        checks++;
        if (b_l0.size() != 16) begin
            failures++;
            $display("FAIL %s_beats got=%0d want=16", tag, b_l0.size());
        end
        for (int i = 0; i < 16 && i < b_l0.size(); i++) begin
            checks++;
            if (b_l0[i] !== 16'(exp_k2s2[i]) || b_l1[i] !== 16'(exp_k2s2[i] + 99) ||
                b_first[i] !== (i % 4 == 0) || b_last[i] !== (i % 4 == 3)) begin
                failures++;
                $display("FAIL %s_beat%0d got=%0d/%0d f%b l%b want=%0d/%0d f%b l%b", tag, i,
                         b_l0[i], b_l1[i], b_first[i], b_last[i],
                         exp_k2s2[i], exp_k2s2[i] + 99, (i % 4 == 0), (i % 4 == 3));
            end
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL %s_done got=%0d want=1", tag, done_cnt);
        end
        checks++;
        if (sbad != 0) begin
            failures++;
            $display("FAIL %s_stall_stable got=%0d want=0", tag, sbad);
        end
    endtask

    task automatic test_k3s1();
        int lat;
        int sbad;
        bit tmo;
        int exp_q[$];
        int idx;
        for (int wy = 0; wy < 2; wy++)
            for (int wx = 0; wx < 2; wx++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++)
                        exp_q.push_back((wy + ky) * 4 + wx + kx + 1);
        run_scan(3, 1, 1'b0, lat, sbad, tmo);
        checks++;
        if (tmo || b_l0.size() != 36) begin
            failures++;
            $display("FAIL k3s1_beats got=%0d want=36 (timeout=%b)", b_l0.size(), tmo);
        end
        for (int i = 0; i < 36 && i < b_l0.size(); i++) begin
            checks++;
            if (b_l0[i] !== 16'(exp_q[i]) || b_first[i] !== (i % 9 == 0) ||
                b_last[i] !== (i % 9 == 8)) begin
                failures++;
                $display("FAIL k3s1_beat%0d got=%0d f%b l%b want=%0d", i, b_l0[i],
                         b_first[i], b_last[i], exp_q[i]);
            end
        end
        if (b_l0.size() == 36) begin
            for (int i = 0; i < 9; i++) begin
                idx = 27 + i;
                checks++;
                if (b_l0[idx] !== 16'(exp_k3s1_tail[i])) begin
                    failures++;
                    $display("FAIL k3s1_tail%0d got=%0d want=%0d", i, b_l0[idx], exp_k3s1_tail[i]);
                end
            end
            checks++;
            if (b_l1[35] !== 16'd115) begin
                failures++;
                $display("FAIL k3s1_lane1_last got=%0d want=115", b_l1[35]);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL k3s1_done got=%0d want=1", done_cnt);
        end
    endtask

    task automatic test_reject();
        int ks[3] = '{0, 4, 3};
        int ss[3] = '{2, 2, 0};
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            start      = 1'b1;
            kernel_dim = KW'(ks[t]);
            stride     = KW'(ss[t]);
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({cfg_err, busy, out_valid} !== 3'b100) begin
                failures++;
                $display("FAIL reject%0d got=%b want=100 (cfg_err,busy,out_valid)", t,
                         {cfg_err, busy, out_valid});
            end
            @(negedge clk);
            checks++;
            if ({cfg_err, busy, out_valid} !== 3'b000) begin
                failures++;
                $display("FAIL reject%0d_after got=%b want=000", t, {cfg_err, busy, out_valid});
            end
        end
    endtask

    task automatic test_k3s3();
        int lat;
        int sbad;
        bit tmo;
        run_scan(3, 3, 1'b0, lat, sbad, tmo);
        checks++;
        if (tmo || b_l0.size() != 9) begin
            failures++;
            $display("FAIL k3s3_beats got=%0d want=9 (timeout=%b)", b_l0.size(), tmo);
        end
        for (int i = 0; i < 9 && i < b_l0.size(); i++) begin
            checks++;
            if (b_l0[i] !== 16'(exp_k3s3[i]) || b_first[i] !== (i == 0) || b_last[i] !== (i == 8)) begin
                failures++;
                $display("FAIL k3s3_beat%0d got=%0d f%b l%b want=%0d", i, b_l0[i],
                         b_first[i], b_last[i], exp_k3s3[i]);
            end
        end
    endtask

    task automatic test_abort();
        int got;
        int c;
        int dseen;
        int lat;
        int sbad;
        bit tmo;
        logic [DW-1:0] fifth;
        got   = 0;
        c     = 0;
        fifth = '0;
        @(negedge clk);
        start      = 1'b1;
        kernel_dim = KW'(2);
        stride     = KW'(2);
        out_ready  = 1'b1;
        while (got < 5 && c < 100) begin
            @(negedge clk);
            start = 1'b0;
            c++;
            if (out_valid) begin
                got++;
                fifth = out_data[DW-1:0];
            end
        end
        checks++;
        if (got != 5 || fifth !== 16'd3) begin
            failures++;
            $display("FAIL abort_pre got=%0d beats last=%0d want=5 beats last=3", got, fifth);
        end
        @(negedge clk);
        abort     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL abort_flush got=%b want=000 (out_valid,busy,done)", {out_valid, busy, done});
        end
        dseen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || out_valid) dseen++;
        end
        checks++;
        if (dseen != 0) begin
            failures++;
            $display("FAIL abort_quiet got=%0d want=0", dseen);
        end
        run_scan(2, 2, 1'b0, lat, sbad, tmo);
        checks++;
        if (tmo || b_l0.size() != 16 || b_l0[0] !== 16'd1 || b_first[0] !== 1'b1) begin
            failures++;
            $display("FAIL abort_replay got=%0d beats first=%0d want=16 beats first=1", b_l0.size(),
                     (b_l0.size() > 0) ? int'(b_l0[0]) : -1);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start      = 1'b1;
        kernel_dim = KW'(3);
        stride     = KW'(1);
        out_ready  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, out_valid} !== 2'b11) begin
            failures++;
            $display("FAIL reset_mid_pre got=%b want=11 (busy,out_valid)", {busy, out_valid});
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, done, cfg_err, out_first, out_last} !== 6'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_mid got=%b data=%h want=000000 data=0",
                     {out_valid, busy, done, cfg_err, out_first, out_last}, out_data);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        load_memory();
        test_k2s2(1'b0, "k2s2");
        test_k3s1();
        test_k2s2(1'b1, "k2s2_bp");
        test_reject();
        test_k3s3();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
